mem_arbiter: RTL and testbench

- Dynamic arbiter for the single-ported memory unit. It replaces the static select-driven memory mux.
- NREQ requesters (MTU, execute, cell, incr, equal) issue level-held requests. The arbiter grants one at a time, round-robin, and forwards that requester's command to the memory unit.
- It sequences the memory execute/ready handshake and returns a one-cycle done pulse to the granted requester.
- It optionally locks the grant across back-to-back transactions (read-modify-write) and flags memory hangs with a timeout.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle for the dynamic memory arbiter.
// The slave side is the arbiter; the master side is the requesters plus the memory unit.
interface mem_arbiter_if #(
    parameter int NREQ   = 5,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_lock;
    logic [2*NREQ-1:0]      req_func;
    logic [ADDR_W*NREQ-1:0] req_addr1;
    logic [ADDR_W*NREQ-1:0] req_addr2;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        grant;
    logic [2:0]             grant_id;
    logic                   busy;
    logic                   timeout_err;
    logic                   mem_ready;
    logic                   mem_execute;
    logic [1:0]             mem_func;
    logic [ADDR_W-1:0]      address1;
    logic [ADDR_W-1:0]      address2;
    logic [DATA_W-1:0]      write_data;

    modport slave (
        input  req_valid, req_lock, req_func, req_addr1, req_addr2, req_wdata, mem_ready,
        output req_done, grant, grant_id, busy, timeout_err,
               mem_execute, mem_func, address1, address2, write_data
    );

    modport master (
        output req_valid, req_lock, req_func, req_addr1, req_addr2, req_wdata, mem_ready,
        input  req_done, grant, grant_id, busy, timeout_err,
               mem_execute, mem_func, address1, address2, write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-ported memory unit: grants one requester,
// forwards its captured command, runs the execute/ready handshake, pulses done.
module mem_arbiter #(
    parameter int NREQ    = 5,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int IDW = 3;
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_e;

    state_e            state_q;
    logic [NREQ-1:0]   grant_q, done_q;
    logic [IDW-1:0]    gid_q, rr_q;
    logic              busy_q, exec_q, terr_q, lock_q;
    logic [1:0]        func_q;
    logic [ADDR_W-1:0] a1_q, a2_q;
    logic [DATA_W-1:0] wd_q;
    logic [15:0]       timer_q;

    logic              pick_vld;
    logic [IDW-1:0]    pick_idx;

    // First valid requester after the last winner, wrapping at NREQ.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_vld && bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(idx);
            end
        end
    end

    logic              own_vld, sel_go, sel_lk;
    logic [IDW-1:0]    sel_idx;
    logic [NREQ-1:0]   sel_oh;
    logic [1:0]        sel_fn;
    logic [ADDR_W-1:0] sel_a1, sel_a2;
    logic [DATA_W-1:0] sel_wd;

    // While locked only the current owner may be re-issued.
    assign own_vld = |(bus.req_valid & grant_q);
    assign sel_idx = lock_q ? gid_q : pick_idx;
    assign sel_go  = bus.mem_ready && (lock_q ? own_vld : pick_vld);

    always_comb begin
        sel_oh = '0;
        sel_fn = '0;
        sel_a1 = '0;
        sel_a2 = '0;
        sel_wd = '0;
        sel_lk = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == sel_idx) begin
                sel_oh[i] = 1'b1;
                sel_fn    = bus.req_func[2*i +: 2];
                sel_a1    = bus.req_addr1[i*ADDR_W +: ADDR_W];
                sel_a2    = bus.req_addr2[i*ADDR_W +: ADDR_W];
                sel_wd    = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_lk    = bus.req_lock[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            gid_q   <= '0;
            rr_q    <= IDW'(NREQ - 1);
            busy_q  <= 1'b0;
            exec_q  <= 1'b0;
            terr_q  <= 1'b0;
            lock_q  <= 1'b0;
            func_q  <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            wd_q    <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lock_q && !own_vld) begin
                        lock_q  <= 1'b0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (sel_go) begin
                        grant_q <= sel_oh;
                        gid_q   <= sel_idx;
                        rr_q    <= sel_idx;
                        lock_q  <= sel_lk;
                        func_q  <= sel_fn;
                        a1_q    <= sel_a1;
                        a2_q    <= sel_a2;
                        wd_q    <= sel_wd;
                        exec_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    exec_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.mem_ready) begin
                        timer_q <= '0;
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TMO) begin
                        terr_q  <= 1'b1;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.mem_ready) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else if (timer_q == TMO) begin
                        terr_q  <= 1'b1;
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    state_q <= IDLE;
                    if (!lock_q) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_done    = done_q;
    assign bus.grant       = grant_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.mem_execute = exec_q;
    assign bus.mem_func    = func_q;
    assign bus.address1    = a1_q;
    assign bus.address2    = a2_q;
    assign bus.write_data  = wd_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level round-robin/lock model
// plus a simple latency-programmable memory responder.
module tb_mem_arbiter;
    localparam int NREQ = 5;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int TMO  = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int mptr;

    logic [1:0]    c_fn [NREQ];
    logic [AW-1:0] c_a1 [NREQ];
    logic [AW-1:0] c_a2 [NREQ];
    logic [DW-1:0] c_wd [NREQ];

    // Memory: ready drops ack_dly cycles after execute and stays low busy_len cycles.
    int ncyc = 0, drop_at = -1, rise_at = -1;
    int ack_dly = 1, busy_len = 3;
    bit hang = 0, force_low = 0;
    always @(negedge clk) begin
        ncyc++;
        if (bus.mem_execute === 1'b1 && !hang) begin
            drop_at = ncyc + ack_dly;
            rise_at = drop_at + busy_len;
        end
        bus.mem_ready = !force_low && !(ncyc >= drop_at && ncyc < rise_at);
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (!$onehot0(bus.grant) || !$onehot0(bus.req_done)) begin
                errors++;
                $display("FAIL onehot: grant=%b done=%b required at most one bit each", bus.grant, bus.req_done);
            end
        end
    end

    function automatic int winner(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++)
            if (m[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        return -1;
    endfunction

    task automatic rand_cmd(input int i);
        c_fn[i] = 2'($urandom);
        c_a1[i] = AW'($urandom);
        c_a2[i] = AW'($urandom);
        c_wd[i] = DW'($urandom);
    endtask

    task automatic apply(input logic [NREQ-1:0] m, input logic [NREQ-1:0] lk);
        bus.req_valid = m;
        bus.req_lock  = lk;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_func[2*i +: 2]    = c_fn[i];
            bus.req_addr1[i*AW +: AW] = c_a1[i];
            bus.req_addr2[i*AW +: AW] = c_a2[i];
            bus.req_wdata[i*DW +: DW] = c_wd[i];
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.grant != 0) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output bit ok, output bit busy_drop);
        ok = 0; d = '0; busy_drop = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_drop = 1;
            if (bus.req_done != 0) begin d = bus.req_done; ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mptr = NREQ - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.grant, bus.grant_id, bus.req_done} !== '0) begin
            errors++;
            $display("FAIL reset_grant: grant=%b id=%0d done=%b required 0", bus.grant, bus.grant_id, bus.req_done);
        end
        checks++;
        if ({bus.busy, bus.mem_execute, bus.timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy=%b exec=%b terr=%b required 0", bus.busy, bus.mem_execute, bus.timeout_err);
        end
        checks++;
        if ({bus.mem_func, bus.address1, bus.address2, bus.write_data} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: func=%0h a1=%0h a2=%0h wd=%0h required 0",
                     bus.mem_func, bus.address1, bus.address2, bus.write_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] m, d;
        bit ok, bd;
        int exp;
        m = 5'b10011;
        for (int i = 0; i < NREQ; i++) rand_cmd(i);
        apply(m, '0);
        for (int t = 0; t < 26; t++) begin
            exp = winner(m);
            wait_done(d, ok, bd);
            checks++;
            if (!ok || d !== NREQ'(1 << exp) || bus.grant_id !== 3'(exp)) begin
                errors++;
                $display("FAIL rr_order[%0d]: done=%b id=%0d required %b id=%0d", t, d, bus.grant_id, NREQ'(1 << exp), exp);
            end
            checks++;
            if (bus.address1 !== c_a1[exp] || bus.address2 !== c_a2[exp] ||
                bus.mem_func !== c_fn[exp] || bus.write_data !== c_wd[exp]) begin
                errors++;
                $display("FAIL rr_cmd[%0d]: a1=%0h a2=%0h fn=%0h wd=%0h required %0h %0h %0h %0h", t,
                         bus.address1, bus.address2, bus.mem_func, bus.write_data,
                         c_a1[exp], c_a2[exp], c_fn[exp], c_wd[exp]);
            end
            mptr = exp;
            @(posedge clk); #1;
            rand_cmd(exp);
            ack_dly  = $urandom_range(1, 2);
            busy_len = $urandom_range(1, 4);
            if (t == 25) m = '0;
            else if (t >= 5) m = NREQ'($urandom_range(1, 31));
            apply(m, '0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== '0) begin
            errors++;
            $display("FAIL rr_idle: busy=%b grant=%b required 0", bus.busy, bus.grant);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] d, g1;
        logic [AW-1:0] a1x;
        logic [1:0] fnx;
        int nexec;
        ack_dly = 1; busy_len = 3;
        c_fn[2] = 2'd2; c_a1[2] = 16'd10; c_a2[2] = 16'h1234; c_wd[2] = 16'hbeef;
        apply(5'b00100, '0);
        nexec = 0; g1 = '0; d = '0; a1x = '0; fnx = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (g1 == 0) g1 = bus.grant;
            if (bus.mem_execute) begin nexec++; a1x = bus.address1; fnx = bus.mem_func; end
            if (bus.req_done != 0) begin d = bus.req_done; break; end
        end
        checks++;
        if (g1 !== 5'b00100 || d !== 5'b00100) begin
            errors++;
            $display("FAIL single_grant: grant=%b done=%b required 00100", g1, d);
        end
        checks++;
        if (nexec != 1 || a1x !== 16'd10 || fnx !== 2'd2) begin
            errors++;
            $display("FAIL single_exec: pulses=%0d a1=%0d fn=%0d required 1 10 2", nexec, a1x, fnx);
        end
        mptr = 2;
        @(posedge clk); #1;
        apply('0, '0);
        @(negedge clk);
        checks++;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b required 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] d;
        bit ok, bd;
        rand_cmd(3); rand_cmd(1);
        apply(5'b01000, 5'b01000);
        wait_grant(ok);
        checks++;
        if (!ok || bus.grant !== 5'b01000) begin
            errors++;
            $display("FAIL lock_grant: grant=%b required 01000", bus.grant);
        end
        apply(5'b01010, 5'b01000);
        wait_done(d, ok, bd);
        checks++;
        if (!ok || d !== 5'b01000 || bd) begin
            errors++;
            $display("FAIL lock_first: done=%b busy_drop=%0d required 01000 0", d, bd);
        end
        @(posedge clk); #1;
        rand_cmd(3);
        apply(5'b01010, 5'b00000);
        wait_done(d, ok, bd);
        checks++;
        if (!ok || d !== 5'b01000 || bd) begin
            errors++;
            $display("FAIL lock_second: done=%b busy_drop=%0d required 01000 0", d, bd);
        end
        mptr = 3;
        @(posedge clk); #1;
        apply(5'b00010, '0);
        wait_done(d, ok, bd);
        checks++;
        if (!ok || d !== NREQ'(1 << winner(5'b00010))) begin
            errors++;
            $display("FAIL lock_handoff: done=%b required 00010", d);
        end
        mptr = 1;
        @(posedge clk); #1;
        apply(5'b01000, 5'b01000);
        wait_done(d, ok, bd);
        mptr = 3;
        @(posedge clk); #1;
        apply('0, '0);
        @(negedge clk);
        checks++;
        if (bus.grant !== 5'b01000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold: grant=%b busy=%b required 01000 1", bus.grant, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop: grant=%b busy=%b required 0 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] d;
        bit ok, bd;
        int n;
        hang = 1;
        rand_cmd(0);
        apply(5'b00001, '0);
        wait_grant(ok);
        n = 0; d = '0;
        for (int i = 1; i < 3 * TMO; i++) begin
            @(negedge clk);
            if (bus.req_done != 0) begin n = i; d = bus.req_done; break; end
        end
        checks++;
        if (!ok || n != TMO + 2 || d !== 5'b00001) begin
            errors++;
            $display("FAIL timeout_latency: cycles=%0d done=%b required %0d 00001", n, d, TMO + 2);
        end
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: terr=%b required 1", bus.timeout_err);
        end
        mptr = 0;
        @(posedge clk); #1;
        hang = 0;
        rand_cmd(2);
        apply(5'b00100, '0);
        wait_done(d, ok, bd);
        checks++;
        if (!ok || d !== 5'b00100 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: done=%b terr=%b required 00100 1", d, bus.timeout_err);
        end
        mptr = 2;
        @(posedge clk); #1;
        apply('0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        logic [NREQ-1:0] d;
        bit ok, bd;
        int bad;
        ack_dly = 1; busy_len = 10;
        rand_cmd(2);
        apply(5'b00100, '0);
        wait_grant(ok);
        repeat (3) @(negedge clk);
        force_low = 1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.grant, bus.busy, bus.req_done, bus.mem_execute, bus.timeout_err, bus.address1} !== '0) begin
            errors++;
            $display("FAIL midop_reset: grant=%b busy=%b done=%b exec=%b terr=%b a1=%0h required 0",
                     bus.grant, bus.busy, bus.req_done, bus.mem_execute, bus.timeout_err, bus.address1);
        end
        rst = 1'b1;
        mptr = NREQ - 1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.grant != 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midop_hold: grants_while_not_ready=%0d required 0", bad);
        end
        force_low = 0;
        busy_len = 3;
        wait_done(d, ok, bd);
        checks++;
        if (!ok || d !== 5'b00100 || bus.address1 !== c_a1[2]) begin
            errors++;
            $display("FAIL midop_resume: done=%b a1=%0h required 00100 %0h", d, bus.address1, c_a1[2]);
        end
        mptr = 2;
        @(posedge clk); #1;
        apply('0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cmd_capture();
        logic [NREQ-1:0] d;
        bit ok;
        int bad;
        rand_cmd(0);
        c_a1[0] = 16'd10;
        apply(5'b00001, '0);
        wait_grant(ok);
        c_a1[0] = 16'd20;
        apply(5'b00001, '0);
        bad = 0; d = '0;
        for (int i = 0; i < 200; i++) begin
            if (bus.address1 !== 16'd10) bad++;
            if (bus.req_done != 0) begin d = bus.req_done; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || bad != 0 || d !== 5'b00001) begin
            errors++;
            $display("FAIL cmd_capture: a1_changes=%0d done=%b a1=%0d required 0 00001 10", bad, d, bus.address1);
        end
        mptr = 0;
        @(posedge clk); #1;
        apply('0, '0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c_fn[i] = '0; c_a1[i] = '0; c_a2[i] = '0; c_wd[i] = '0;
        end
        apply('0, '0);
        test_reset();
        test_contention();
        test_single();
        test_lock();
        test_timeout();
        test_reset_midop();
        test_cmd_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
